alu_ctrl_seq: RTL and testbench

Parametrised, registered ALU control unit with a valid/ready handshake. It decodes `ALUOp`/`Funct` into the ALU `Operation` code, including the full RV32I R-type set. For `MUL` it sequences `MUL_STEPS` shift-add step beats to the datapath. It sits between the decode stage and the ALU/multiplier datapath.

---
 rtl/alu_ctrl_seq.sv | 217 +++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control unit with valid/ready handshake.
// Decodes ALUOp/Funct into the ALU Operation code (full RV32I R-type set)
// and sequences MUL_STEPS shift-add step beats for MUL.
// Optional feature macro: ALU_CTRL_ILLEGAL_TRAP_EN
//   defined   -> illegal decodes emit ILLEGAL (1111) and set sticky 'illegal'
//   undefined -> illegal decodes emit ADD (0010), 'illegal' tied low
module alu_ctrl_seq #(
  parameter int OP_W      = 4,                  // >= 4, upper bits zero-filled
  parameter int MUL_STEPS = 32,                 // >= 2
  parameter int STEP_W    = $clog2(MUL_STEPS)   // derived, do not override
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Funct,
  input  logic [1:0]        ALUOp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   Operation,
  output logic [STEP_W-1:0] step,
  output logic              out_last,
  output logic              illegal
);

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_XOR     = 4'b0011;
  localparam logic [3:0] OP_SLL     = 4'b0100;
  localparam logic [3:0] OP_SRL     = 4'b0101;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_SLT     = 4'b0111;
  localparam logic [3:0] OP_SRA     = 4'b1000;
  localparam logic [3:0] OP_SLTU    = 4'b1001;
  localparam logic [3:0] OP_MULSTEP = 4'b1100;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MUL_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } state_e;

  // Decode result packed as {op[3:0], is_mul, is_illegal}.
  function automatic logic [5:0] decode(input logic [1:0] alu_op,
                                        input logic [3:0] funct);
    logic [5:0] res;
    res = {OP_ILLEGAL, 1'b0, 1'b1};
    case (alu_op)
      2'b00: res = {OP_ADD, 1'b0, 1'b0};
      2'b01: res = {OP_SUB, 1'b0, 1'b0};
      2'b10: begin
        case (funct)
          4'b0000: res = {OP_ADD,  1'b0, 1'b0};
          4'b1000: res = {OP_SUB,  1'b0, 1'b0};
          4'b0111: res = {OP_AND,  1'b0, 1'b0};
          4'b0110: res = {OP_OR,   1'b0, 1'b0};
          4'b0100: res = {OP_XOR,  1'b0, 1'b0};
          4'b0001: res = {OP_SLL,  1'b0, 1'b0};
          4'b0101: res = {OP_SRL,  1'b0, 1'b0};
          4'b1101: res = {OP_SRA,  1'b0, 1'b0};
          4'b0010: res = {OP_SLT,  1'b0, 1'b0};
          4'b0011: res = {OP_SLTU, 1'b0, 1'b0};
          default: res = {OP_ILLEGAL, 1'b0, 1'b1};
        endcase
      end
      2'b11: begin
        // funct7[5] (Funct[3]) does not distinguish MUL here
        if (funct[2:0] == 3'b000) begin
          res = {OP_MULSTEP, 1'b1, 1'b0};
        end else begin
          res = {OP_ILLEGAL, 1'b0, 1'b1};
        end
      end
      default: res = {OP_ILLEGAL, 1'b0, 1'b1};
    endcase
    return res;
  endfunction

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                last_q, last_d;

  logic [5:0]          dec_s;
  logic [3:0]          dec_op_s;
  logic                dec_mul_s;
  logic                dec_ill_s;
  logic                accept_s;
  logic                consume_s;

  // Decode the request and resolve how an illegal combination is reported.
  always_comb begin
    dec_s     = decode(ALUOp, Funct);
    dec_mul_s = dec_s[1];
    dec_ill_s = dec_s[0];
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    dec_op_s  = dec_s[5:2];
`else
    dec_op_s  = dec_ill_s ? OP_ADD : dec_s[5:2];
`endif
  end

  assign in_ready  = (state_q == ST_IDLE) & (~out_valid_q | out_ready);
  assign accept_s  = in_valid & in_ready;
  assign consume_s = out_valid_q & out_ready;

  // State register plus the output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      step_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      step_q      <= step_d;
      last_q      <= last_d;
    end
  end

  // Next-state logic: MUL enters MULTI, the consumed last beat leaves it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && dec_mul_s) begin
          state_d = ST_MULTI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MULTI: begin
        if (consume_s && last_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_MULTI;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register next values; everything holds while a beat is stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    op_d        = op_q;
    step_d      = step_q;
    last_d      = last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          out_valid_d = 1'b1;
          op_d        = OP_W'(dec_op_s);
          step_d      = '0;
          last_d      = ~dec_mul_s;
        end else if (consume_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      ST_MULTI: begin
        if (consume_s && last_q) begin
          out_valid_d = 1'b0;
        end else if (consume_s) begin
          step_d = step_q + STEP_ONE;
          last_d = ((step_q + STEP_ONE) == STEP_LAST);
        end else begin
          step_d = step_q;
        end
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign Operation = op_q;
  assign step      = step_q;
  assign out_last  = last_q;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky illegal flag, set by the accept of an illegal decode.
  always_comb begin
    if (accept_s && dec_ill_s) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // Illegal flag register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed testbench for alu_ctrl_seq with a scoreboard of expected beats.
module tb_alu_ctrl_seq;

  localparam int OP_W      = 4;
  localparam int MUL_STEPS = 4;
  localparam int STEP_W    = $clog2(MUL_STEPS);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] EXP_ILL_OP   = 4'b1111;
  localparam logic       EXP_ILL_FLAG = 1'b1;
`else
  localparam logic [3:0] EXP_ILL_OP   = 4'b0010;
  localparam logic       EXP_ILL_FLAG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        Funct;
  logic [1:0]        ALUOp;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   Operation;
  logic [STEP_W-1:0] step;
  logic              out_last;
  logic              illegal;

  typedef struct packed {
    logic [3:0]        op;
    logic [STEP_W-1:0] step;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks = 0;
  int    errors = 0;

  logic [3:0] rt_funct [10] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                                4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011};
  logic [3:0] rt_op    [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011,
                                4'b0100, 4'b0101, 4'b1000, 4'b0111, 4'b1001};

  alu_ctrl_seq #(.OP_W(OP_W), .MUL_STEPS(MUL_STEPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Funct     (Funct),
    .ALUOp     (ALUOp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Operation (Operation),
    .step      (step),
    .out_last  (out_last),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_single(input logic [3:0] op);
    beat_t b;
    b.op   = op;
    b.step = '0;
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  task automatic push_mul(input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.op   = 4'b1100;
      b.step = STEP_W'(i);
      b.last = (i == MUL_STEPS - 1);
      exp_q.push_back(b);
    end
  endtask

  // Scoreboard monitor: every beat that is consumed at the next edge is compared.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sb_op",   32'(Operation), 32'(mon_e.op));
        check("sb_step", 32'(step),      32'(mon_e.step));
        check("sb_last", 32'(out_last),  32'(mon_e.last));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    Funct     = 4'b0000;
    ALUOp     = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_operation", 32'(Operation), 32'd0);
    check("rst_step",      32'(step),      32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_illegal",   32'(illegal),   32'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Back-to-back R-type decodes: OR, SUB, SRA
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ALUOp     = 2'b10;
    Funct = 4'b0110; push_single(4'b0001); tick();
    check("b2b_in_ready1", 32'(in_ready), 32'd1);
    Funct = 4'b1000; push_single(4'b0110); tick();
    check("b2b_in_ready2", 32'(in_ready), 32'd1);
    Funct = 4'b1101; push_single(4'b1000); tick();
    in_valid = 1'b0;
    check("b2b_last_valid", 32'(out_valid), 32'd1);
    tick();
    check("b2b_drained", 32'(out_valid), 32'd0);

    // Full R-type table streamed at one request per cycle
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Funct = rt_funct[i];
      push_single(rt_op[i]);
      check("rt_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Load/store add with downstream stall; Funct is ignored
    ALUOp     = 2'b00;
    Funct     = 4'b1111;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    push_single(4'b0010);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_operation", 32'(Operation), 32'd2);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("stall_consumed", 32'(out_valid), 32'd0);

    // MUL with out_ready=1; in_valid held during MULTI must be ignored
    ALUOp    = 2'b11;
    Funct    = 4'b0000;
    in_valid = 1'b1;
    push_mul(MUL_STEPS);
    tick();
    ALUOp = 2'b01;
    for (int i = 0; i < MUL_STEPS; i++) begin
      check("mul_in_ready",  32'(in_ready),  32'd0);
      check("mul_out_valid", 32'(out_valid), 32'd1);
      if (i == MUL_STEPS - 1) in_valid = 1'b0;
      tick();
    end
    check("mul_done_valid", 32'(out_valid), 32'd0);
    check("mul_done_ready", 32'(in_ready),  32'd1);

    // MUL with toggling out_ready; Funct[3] set (ignored)
    ALUOp    = 2'b11;
    Funct    = 4'b1000;
    in_valid = 1'b1;
    push_mul(MUL_STEPS);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2 * MUL_STEPS; k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    check("tog_done_valid", 32'(out_valid), 32'd0);

    // Reset asserted at step 2 of a MUL
    out_ready = 1'b1;
    ALUOp     = 2'b11;
    Funct     = 4'b0000;
    in_valid  = 1'b1;
    push_mul(2);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;
    check("mrst_step2", 32'(step), 32'd2);
    reset = 1'b1;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_operation", 32'(Operation), 32'd0);
    check("mrst_step",      32'(step),      32'd0);
    check("mrst_out_last",  32'(out_last),  32'd0);
    #2;
    reset = 1'b0;
    tick();
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    ALUOp     = 2'b01;
    Funct     = 4'b0111;
    in_valid  = 1'b1;
    push_single(4'b0110);
    tick();
    in_valid = 1'b0;
    tick();

    // Illegal decode
    check("ill_before", 32'(illegal), 32'd0);
    ALUOp    = 2'b11;
    Funct    = 4'b0001;
    in_valid = 1'b1;
    push_single(EXP_ILL_OP);
    tick();
    in_valid = 1'b0;
    check("ill_flag_beat", 32'(illegal), 32'(EXP_ILL_FLAG));
    tick();
    ALUOp    = 2'b01;
    in_valid = 1'b1;
    push_single(4'b0110);
    tick();
    in_valid = 1'b0;
    tick();
    check("ill_flag_sticky", 32'(illegal), 32'(EXP_ILL_FLAG));

    tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
